// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronise and deglitch the pins, deframe 11-bit frames, fold E0/F0
// prefixes into flags and queue key events. Define KB_PARITY_CHECK_EN to reject bad-parity frames.
module ps2_kb_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 25000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        kb_ps2_clk_in,
  input  logic        kb_ps2_data_in,
  input  logic        kb_rd,
  output logic [15:0] kb_data,
  output logic        kb_ready,
  output logic        kb_overflow,
  output logic        frame_err
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN);
  localparam int unsigned ToW   = $clog2(TIMEOUT + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StShift, StParity, StStop} state_e;

  // Index 0 is the PS/2 clock, index 1 the PS/2 data.
  logic [1:0]       clk_sync_q, data_sync_q;
  logic [1:0]       raw, filt_q;
  logic [FiltW-1:0] cnt_q [2];
  logic             fclk_prev_q;
  logic             fall, sdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 2'b11;
      fclk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], kb_ps2_clk_in};
      data_sync_q <= {data_sync_q[0], kb_ps2_data_in};
      fclk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == FiltW'(FILTER_LEN - 1)) begin
          filt_q[i] <= raw[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign raw   = {data_sync_q[1], clk_sync_q[1]};
  assign fall  = fclk_prev_q & ~filt_q[0];
  assign sdata = filt_q[1];

  state_e         state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [ToW-1:0] to_q, to_d;
  logic           ext_q, ext_d, brk_q, brk_d;
  logic           err_d, par_ok, byte_ok, timeout, push;
  logic [9:0]     push_data;

`ifdef KB_PARITY_CHECK_EN
  assign par_ok = ^{shift_q, par_q};
`else
  // Parity bit is still latched but never rejects a frame.
  assign par_ok = (^{shift_q, par_q}) | 1'b1;
`endif

  assign timeout = (state_q != StIdle) && !fall && (to_q >= ToW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    err_d     = 1'b0;
    byte_ok   = 1'b0;
    push      = 1'b0;
    push_data = {ext_q, brk_q, shift_q};
    to_d      = (fall || state_q == StIdle) ? '0 : to_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (fall && !sdata) begin
          state_d  = StShift;
          bitcnt_d = 3'd0;
        end
      end
      StShift: begin
        if (fall) begin
          shift_d  = {sdata, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = sdata;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          byte_ok = sdata && par_ok;
          err_d   = !byte_ok;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end

    if (byte_ok) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    if (err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_q      <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_q      <= to_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      frame_err <= err_d;
    end
  end

  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        empty, full, do_pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = kb_rd && !empty;
  // A same-cycle pop frees the slot the push needs.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q        <= '0;
      rd_q        <= '0;
      kb_overflow <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (push && !do_push) kb_overflow <= 1'b1;
    end
  end

  assign kb_ready = !empty;
  assign kb_data  = empty ? 16'h0000 : {6'b0, mem_q[rd_q[AW-1:0]]};

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Bench for ps2_kb_rx: drives PS/2 frames and checks outputs against a queue-based event model.
module tb_ps2_kb_rx;
  localparam int unsigned FiltLen = 8;
  localparam int unsigned Timeout = 200;
  localparam int unsigned Depth   = 8;
  localparam int unsigned Half    = 20;
`ifdef KB_PARITY_CHECK_EN
  localparam bit ParChk = 1'b1;
`else
  localparam bit ParChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2c = 1'b1;
  logic        ps2d = 1'b1;
  logic        kb_rd = 1'b0;
  logic [15:0] kb_data;
  logic        kb_ready, kb_overflow, frame_err;

  always #5 clk = ~clk;

  ps2_kb_rx #(
    .FILTER_LEN (FiltLen),
    .TIMEOUT    (Timeout),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .kb_ps2_clk_in  (ps2c),
    .kb_ps2_data_in (ps2d),
    .kb_rd          (kb_rd),
    .kb_data        (kb_data),
    .kb_ready       (kb_ready),
    .kb_overflow    (kb_overflow),
    .frame_err      (frame_err)
  );

  logic [9:0] q[$];
  bit         m_ext, m_brk, m_ovf;
  int         err_exp = 0;
  int         err_seen = 0;
  bit         settled = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) if (frame_err) err_seen++;

  always @(negedge clk) begin
    if (settled) begin
      check("model_ready", int'(kb_ready), (q.size() != 0) ? 1 : 0);
      check("model_data", int'(kb_data), (q.size() != 0) ? int'(q[0]) : 0);
      check("model_ovf", int'(kb_overflow), int'(m_ovf));
      check("model_errcnt", err_seen, err_exp);
    end
  end

  // Event-level model: what a complete frame means to the keyboard event stream.
  task automatic apply_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
    if (!stop_ok || (ParChk && !par_ok)) begin
      err_exp++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (q.size() < Depth) q.push_back({m_ext, m_brk, b});
      else m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at,
                           input bit pop_at_stop);
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      cyc(Half);
      ps2c = 1'b0;
      if (pop_at_stop && i == 10) begin
        // 2 sync flops + FILTER_LEN samples + edge register: the push lands on this pop.
        cyc(FiltLen + 2);
        kb_rd = 1'b1;
        cyc(1);
        kb_rd = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        cyc(Half - FiltLen - 3);
      end else begin
        cyc(Half);
      end
      ps2c = 1'b1;
      if (i == glitch_at) begin
        cyc(Half / 2);
        ps2c = 1'b0;
        cyc(2);
        ps2c = 1'b1;
      end
    end
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                       input int glitch_at = -1, input bit pop_at_stop = 1'b0);
    logic par;
    par = (~^b) ^ bad_par;
    settled = 1'b0;
    send_bits({~bad_stop, par, b, 1'b0}, 11, glitch_at, pop_at_stop);
    ps2d = 1'b1;
    cyc(Half);
    apply_frame(b, !bad_par, !bad_stop);
    settled = 1'b1;
  endtask

  task automatic pop();
    kb_rd = 1'b1;
    cyc(1);
    kb_rd = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic do_reset();
    settled = 1'b0;
    ps2c = 1'b1;
    ps2d = 1'b1;
    reset = 1'b0;
    q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(2);
    settled = 1'b1;
  endtask

  logic [7:0] codes [9];
  int         e0;
  logic [7:0] rb;

  initial begin
    codes[0] = 8'h15; codes[1] = 8'h16; codes[2] = 8'h1D; codes[3] = 8'h24; codes[4] = 8'h2D;
    codes[5] = 8'h2C; codes[6] = 8'h35; codes[7] = 8'h3C; codes[8] = 8'h43;

    cyc(3);
    check("rst_ready", int'(kb_ready), 0);
    check("rst_data", int'(kb_data), 0);
    check("rst_ovf", int'(kb_overflow), 0);
    check("rst_err", int'(frame_err), 0);
    reset = 1'b1;
    cyc(2);
    settled = 1'b1;

    frame(8'h1C, 1'b0, 1'b0);
    check("one_ready", int'(kb_ready), 1);
    check("one_data", int'(kb_data), 16'h001C);
    pop();
    check("one_popped", int'(kb_ready), 0);

    frame(8'hE0, 1'b0, 1'b0);
    frame(8'hF0, 1'b0, 1'b0);
    check("prefix_noevent", int'(kb_ready), 0);
    frame(8'h74, 1'b0, 1'b0);
    check("extbrk_data", int'(kb_data), 16'h0374);
    pop();
    check("extbrk_single", int'(kb_ready), 0);

    e0 = err_seen;
    frame(8'h1C, 1'b1, 1'b0);
    check("badpar_err", err_seen - e0, ParChk ? 1 : 0);
    check("badpar_ready", int'(kb_ready), ParChk ? 0 : 1);
    check("badpar_data", int'(kb_data), ParChk ? 0 : 16'h001C);
    pop();

    e0 = err_seen;
    settled = 1'b0;
    send_bits({2'b11, 8'h1C, 1'b0}, 5, -1, 1'b0);
    ps2d = 1'b1;
    cyc(Timeout + 40);
    err_exp++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    settled = 1'b1;
    check("timeout_err", err_seen - e0, 1);
    frame(8'h1C, 1'b0, 1'b0);
    check("after_to_data", int'(kb_data), 16'h001C);
    pop();

    // Full FIFO with a pop landing on the push cycle.
    do_reset();
    for (int i = 0; i < 8; i++) frame(codes[i], 1'b0, 1'b0);
    frame(codes[8], 1'b0, 1'b0, -1, 1'b1);
    check("coinc_no_ovf", int'(kb_overflow), 0);
    for (int i = 1; i < 9; i++) begin
      check("coinc_order", int'(kb_data), int'(codes[i]));
      pop();
    end

    for (int i = 0; i < 9; i++) frame(codes[i], 1'b0, 1'b0);
    check("ovf_set", int'(kb_overflow), 1);
    for (int i = 0; i < 8; i++) begin
      check("ovf_order", int'(kb_data), int'(codes[i]));
      pop();
    end
    check("ovf_ninth_lost", int'(kb_ready), 0);

    frame(8'h5A, 1'b0, 1'b0, 3);
    check("glitch_data", int'(kb_data), 16'h005A);
    pop();

    settled = 1'b0;
    send_bits({2'b11, 8'h33, 1'b0}, 6, -1, 1'b0);
    e0 = err_seen;
    do_reset();
    cyc(Timeout + 20);
    check("midrst_noerr", err_seen - e0, 0);
    check("midrst_noevent", int'(kb_ready), 0);
    frame(8'h29, 1'b0, 1'b0);
    check("midrst_next", int'(kb_data), 16'h0029);
    pop();

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(5, 0))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        default: rb = 8'($urandom_range(255, 0));
      endcase
      frame(rb, $urandom_range(7, 0) == 0, $urandom_range(9, 0) == 0);
      repeat ($urandom_range(2, 0)) pop();
    end
    while (q.size() != 0) pop();
    cyc(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
